aes_encrypt_top: RTL and testbench

//  AES-128 encryption engine (FIPS-197). Iterative: one round per clock.

---
 rtl/aes_encrypt_top.sv | 138 +++++++++++++
 tb/tb_aes_encrypt_top.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_top.sv
// Iterative AES-128 encryption engine: one round per enabled clock edge.
// Key expansion runs alongside the rounds, so only the current round key is stored.
module aes_encrypt_top (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
  input  logic         cipher_new_en,
  input  logic         EN,
  output logic         cipher_ready,
  output logic [127:0] cipher_text
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state;
  logic [127:0] rk;
  logic [127:0] next_rk;
  logic [127:0] sr_sb;
  logic [127:0] mixed;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte (row r, column c) sits at index r+4c; ShiftRows pulls row r from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    next_rk = key_exp(rk, rcon_of(round));
    sr_sb   = sub_shift(state);
    mixed   = '0;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = mix_column(sr_sb[127-32*c -: 32]);
  end

  // DONE accepts a start exactly like IDLE; strobes during RUN fall through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm          <= IDLE;
      round        <= '0;
      state        <= '0;
      rk           <= '0;
      cipher_text  <= '0;
      cipher_ready <= 1'b0;
    end else if (EN) begin
      case (fsm)
        RUN: begin
          rk <= next_rk;
          if (round == 4'd10) begin
            state        <= sr_sb ^ next_rk;
            cipher_text  <= sr_sb ^ next_rk;
            cipher_ready <= 1'b1;
            round        <= '0;
            fsm          <= DONE;
          end else begin
            state <= mixed ^ next_rk;
            round <= round + 4'd1;
          end
        end
        default: begin
          if (cipher_new_en) begin
            state        <= plain_text ^ cipher_key;
            rk           <= cipher_key;
            round        <= 4'd1;
            cipher_ready <= 1'b0;
            fsm          <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_top.sv
// Scoreboard bench for aes_encrypt_top, with an independent AES-128 reference model
// whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_encrypt_top;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] plain_text;
  logic [127:0] cipher_key;
  logic         cipher_new_en;
  logic         EN;
  logic         cipher_ready;
  logic [127:0] cipher_text;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_ct;
  logic [7:0]   sbox_m [256];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encrypt_top dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .plain_text   (plain_text),
    .cipher_key   (cipher_key),
    .cipher_new_en(cipher_new_en),
    .EN           (EN),
    .cipher_ready (cipher_ready),
    .cipher_text  (cipher_text)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[r+4*c] = sbox_m[st[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            st[r+4*c] = gmul(tmp[4*c+r], 8'h02) ^ gmul(tmp[4*c+(r+1)%4], 8'h03)
                      ^ tmp[4*c+(r+2)%4] ^ tmp[4*c+(r+3)%4];
          else
            st[r+4*c] = tmp[r+4*c];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Pushes the expected ciphertext, pulses the strobe for one cycle and checks the ready drop.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] expct);
    exp_q.push_back(expct);
    @(negedge clk);
    cipher_key    = key;
    plain_text    = pt;
    cipher_new_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cipher_new_en = 1'b0;
    checkOutput("ready_drop", {127'd0, cipher_ready}, 128'd0);
  endtask

  // mode 0: quiet run; 1: strobe + input change after edge 4; 2: EN low for edges 5..7
  task automatic waitResult(input int mode, input int exp_latency);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (cipher_ready) seen = 1'b1;
      else if (mode == 1 && edges == 4) begin
        cipher_new_en = 1'b1;
        plain_text    = {$urandom(), $urandom(), $urandom(), $urandom()};
        cipher_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if (mode == 1 && edges == 5) cipher_new_en = 1'b0;
      else if (mode == 2 && edges == 4) EN = 1'b0;
      else if (mode == 2 && edges == 7) EN = 1'b1;
    end
    EN            = 1'b1;
    cipher_new_en = 1'b0;
    checkOutput("latency", 128'(edges), 128'(exp_latency));
    if (exp_q.size() > 0) begin
      last_ct = exp_q.pop_front();
      checkOutput("ciphertext", cipher_text, last_ct);
    end else
      checkOutput("scoreboard_empty", 128'd1, 128'd0);
  endtask

  initial begin
    logic [127:0] rkey, rpt;
    reset_n       = 1'b0;
    EN            = 1'b1;
    cipher_new_en = 1'b0;
    plain_text    = '0;
    cipher_key    = '0;
    build_sbox();

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {127'd0, cipher_ready}, 128'd0);
    checkOutput("reset_ct", cipher_text, 128'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_ready", {127'd0, cipher_ready}, 128'd0);
    checkOutput("idle_ct", cipher_text, 128'd0);

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(KEY_C1, PT_C1, CT_C1);
    waitResult(0, 10);
    repeat (3) @(negedge clk);
    checkOutput("hold_ready", {127'd0, cipher_ready}, 128'd1);
    checkOutput("hold_ct", cipher_text, CT_C1);

    $display("[TB] back-to-back blocks");
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32);
    waitResult(0, 10);
    applyStimulus({16{8'ha5}}, PT_C1, aes_model({16{8'ha5}}, PT_C1));
    waitResult(0, 10);
    applyStimulus('0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    waitResult(0, 10);

    rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
    rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(rkey, rpt, aes_model(rkey, rpt));
    waitResult(0, 10);

    $display("[TB] strobe and input changes mid-run");
    applyStimulus(KEY_C1, PT_C1, CT_C1);
    waitResult(1, 10);

    $display("[TB] EN pause mid-run");
    applyStimulus(KEY_C1, PT_C1, CT_C1);
    waitResult(2, 13);

    $display("[TB] reset mid-run");
    @(negedge clk);
    cipher_key    = KEY_C1;
    plain_text    = PT_C1;
    cipher_new_en = 1'b1;
    @(negedge clk);
    cipher_new_en = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_ready", {127'd0, cipher_ready}, 128'd0);
    checkOutput("midrun_reset_ct", cipher_text, 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_reset_ready", {127'd0, cipher_ready}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
